// File: rtl/alu_bist_sequencer.sv
// Self-test sequencer for the ALUControl/ALU pair: steps through a fixed table of
// R-type vectors, holds each for SETTLE cycles, then checks ALUOut and Branch_Enable.
module alu_bist_sequencer #(
    parameter int SETTLE       = 2,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [3:0]  fail_index,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  FuncCode,
    output logic [6:0]  Opcode,
    input  logic [31:0] ALUOut,
    input  logic        Branch_Enable
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [6:0]    OP_RTYPE = 7'b0110011;
    localparam logic [3:0]    LAST_IDX = 4'd8;
    localparam logic [3:0]    NO_FAIL  = 4'hF;

    // Entry layout: {FuncCode[3:0], A[31:0], B[31:0], expected[31:0]}
    function automatic logic [99:0] rom_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_entry = {4'b0111, 32'h0000_000F, 32'h0000_0055, 32'h0000_0005};
            4'd1:    rom_entry = {4'b0110, 32'h0000_000F, 32'h0000_0055, 32'h0000_005F};
            4'd2:    rom_entry = {4'b0000, 32'd10000,     32'd111,       32'd10111};
            4'd3:    rom_entry = {4'b1000, 32'd10000,     32'd111,       32'd9889};
            4'd4:    rom_entry = {4'b0010, 32'd0,         32'd2,         32'd1};
            4'd5:    rom_entry = {4'b0101, 32'h0000_0010, 32'd2,         32'h0000_0004};
            4'd6:    rom_entry = {4'b1101, 32'h8000_0000, 32'd1,         32'hC000_0000};
            4'd7:    rom_entry = {4'b0001, 32'd2,         32'd2,         32'd8};
            4'd8:    rom_entry = {4'b0100, 32'h0000_0055, 32'h0000_00FF, 32'h0000_00AA};
            default: rom_entry = {4'b0000, 32'd0,         32'd0,         32'd0};
        endcase
    endfunction

    state_t        r_state;
    logic [3:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_fail_count;
    logic [3:0]    r_fail_index;
    logic          r_pass;
    logic          r_done;
    logic          r_busy;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [3:0]    r_func;
    logic [6:0]    r_op;

    state_t        w_next_state;
    logic [3:0]    w_next_idx;
    logic [CW-1:0] w_next_cnt;
    logic [3:0]    w_next_fc;
    logic [3:0]    w_next_fi;
    logic          w_next_pass;
    logic [99:0]   w_cur_entry;
    logic [99:0]   w_drv_entry;
    logic          w_mismatch;
    logic          w_drive;

    // Next-state, run bookkeeping and the drive values for the coming cycle
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_cnt   = r_cnt;
        w_next_fc    = r_fail_count;
        w_next_fi    = r_fail_index;
        w_next_pass  = r_pass;
        w_cur_entry  = rom_entry(r_idx);
        w_mismatch   = (ALUOut != w_cur_entry[31:0]) || Branch_Enable;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_APPLY;
                    w_next_idx   = 4'd0;
                    w_next_cnt   = '0;
                    w_next_fc    = 4'd0;
                    w_next_fi    = NO_FAIL;
                    w_next_pass  = 1'b0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_APPLY: begin
                if (r_cnt == CNT_LAST) begin
                    w_next_state = S_CHECK;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    w_next_fc = (r_fail_count == 4'd15) ? 4'd15 : r_fail_count + 4'd1;
                    w_next_fi = (r_fail_index == NO_FAIL) ? r_idx : r_fail_index;
                end else begin
                    w_next_fc = r_fail_count;
                    w_next_fi = r_fail_index;
                end
                // Pass is settled here so it is already valid alongside the done pulse.
                if ((w_mismatch && STOP_ON_FAIL) || (r_idx == LAST_IDX)) begin
                    w_next_state = S_DONE;
                    w_next_pass  = (r_fail_count == 4'd0) && !w_mismatch;
                end else begin
                    w_next_state = S_APPLY;
                    w_next_idx   = r_idx + 4'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        w_drive     = (w_next_state == S_APPLY) || (w_next_state == S_CHECK);
        w_drv_entry = rom_entry(w_next_idx);
    end

    // State, bookkeeping and registered drive outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 4'd0;
            r_cnt        <= '0;
            r_fail_count <= 4'd0;
            r_fail_index <= NO_FAIL;
            r_pass       <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_func       <= 4'd0;
            r_op         <= 7'd0;
        end else begin
            r_state      <= w_next_state;
            r_idx        <= w_next_idx;
            r_cnt        <= w_next_cnt;
            r_fail_count <= w_next_fc;
            r_fail_index <= w_next_fi;
            r_pass       <= w_next_pass;
            r_done       <= (w_next_state == S_DONE);
            r_busy       <= w_drive;
            r_a          <= w_drive ? w_drv_entry[95:64] : 32'd0;
            r_b          <= w_drive ? w_drv_entry[63:32] : 32'd0;
            r_func       <= w_drive ? w_drv_entry[99:96] : 4'd0;
            r_op         <= w_drive ? OP_RTYPE : 7'd0;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign fail_count = r_fail_count;
    assign fail_index = r_fail_index;
    assign A          = r_a;
    assign B          = r_b;
    assign FuncCode   = r_func;
    assign Opcode     = r_op;

endmodule
